// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery of one frame at a time.
// Latency: rxd -> rxs 2 clkin; strobe 1 clkin after the tick sampling stop bit.
// Backpressure: none; rx_valid/frame_err are single-cycle strobes, host must sample.
//
// Ports:
//   clkin     system clock, rising edge
//   rst       synchronous active-high reset
//   tick      one-cycle oversampling enable at OVERSAMPLE x baud
//   rxd       asynchronous serial input, idle high
//   rx_data   last correctly framed byte, held until the next good frame
//   rx_valid  one-cycle pulse when rx_data is updated
//   frame_err one-cycle pulse when the stop bit was sampled low
//   busy      high whenever the receiver is not idle
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic                 rxd_meta_q;
  logic                 rxs_q;
  logic [2:0]           state_q,     state_d;
  logic [SW-1:0]        scnt_q,      scnt_d;
  logic [BW-1:0]        bcnt_q,      bcnt_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  // Two-flop synchronizer; both stages reset to the idle (high) level so a
  // reset never manufactures a start edge.
  always_ff @(posedge clkin) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    // Everything except the strobe clear is gated by tick, so a stalled
    // baud generator freezes the frame in place.
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs_q) begin
            state_d = ST_START;
            scnt_d  = '0;
          end
        end

        ST_START: begin
          // Re-check the line at the start-bit midpoint; a high level here
          // means the falling edge was a glitch.
          if (scnt_q == HALF_M1) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rxs_q ? ST_IDLE : ST_DATA;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (scnt_q == FULL_M1) begin
            scnt_d  = '0;
            shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == LAST_BIT) begin
              state_d = ST_STOP;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          // Leaving at the stop-bit midpoint gives half a bit of slack to
          // catch a start bit that follows immediately.
          if (scnt_q == FULL_M1) begin
            scnt_d = '0;
            if (rxs_q) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end

        ST_BREAK: begin
          // Wait out a held-low line so it cannot start a bogus frame.
          if (rxs_q) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that turns the asynchronous serial line into parallel bytes, one frame at a time. It sits downstream of the baud-rate generator and consumes its output as a single-cycle oversampling enable (`tick`) at OVERSAMPLE × baud, all within the `clkin` domain. Recovered bytes are presented with a one-cycle `rx_valid` strobe to the host-side logic. Framing errors are flagged separately.

## Interface
- OVERSAMPLE, 16: ticks per bit; even, ≥ 4.
- DATA_BITS, 8: data bits per frame (5–8). No parity. One stop bit.
- clkin  in  1  system clock. All logic runs on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- tick  in  1  oversampling enable from the baud generator; one `clkin` cycle wide, OVERSAMPLE × baud rate.
- rxd  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  last correctly framed byte. Holds until the next good frame.
- rx_valid  out  1  one-cycle pulse: `rx_data` updated.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high in any state other than IDLE.

## Operation
- **Input synchronizer:** 2-FF synchronizer on `rxd`; both flops reset to 1. All decisions use the synchronized value `rxs`.
- **Counters:**
  - `scnt`: tick counter, width clog2(OVERSAMPLE); advances only on `tick`.
  - `bcnt`: bit index, width clog2(DATA_BITS)+1.
- **States:** IDLE, START, DATA, STOP, BREAK. Transitions occur only on cycles with `tick` = 1, except reset.
  - **IDLE:** `rxs` = 0 → START, `scnt` = 0.
  - **START:** increment `scnt`. When `scnt` reaches OVERSAMPLE/2−1 (start-bit midpoint):
    - `rxs` = 0 → DATA, with `scnt` = 0 and `bcnt` = 0.
    - `rxs` = 1 → IDLE (glitch rejected; no outputs).
  - **DATA:** increment `scnt`. When `scnt` reaches OVERSAMPLE−1 (next bit midpoint):
    - shift `rxs` into shift register, LSB first;
    - `scnt` = 0, `bcnt` + 1;
    - after DATA_BITS samples → STOP.
  - **STOP:** at `scnt` = OVERSAMPLE−1, sample `rxs`:
    - 1 → `rx_data` ← shift register, `rx_valid` pulse, → IDLE.
    - 0 → `frame_err` pulse, `rx_data` unchanged, → BREAK.
  - **BREAK:** remain until `rxs` = 1, then → IDLE. This prevents a held-low line (break) from retriggering frames.
- **Outputs:** `rx_valid` and `frame_err` are never asserted together. Neither is held for more than one `clkin` cycle.
- **Stalled generator:** `tick` held 0 freezes all state and counters; `rx_valid` and `frame_err` still deassert after one cycle.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `busy` = 0; state = IDLE; counters = 0; sync flops = 1.
- Reset mid-frame aborts the frame with no strobe. The next start is accepted no earlier than 2 `clkin` cycles after `rst` deasserts (synchronizer refill).
- Input latency: `rxd` edge → `rxs` is 2 `clkin` cycles.
- `rx_valid` / `frame_err` assert in the `clkin` cycle after the `tick` that samples the stop bit. `busy` falls in that same cycle.
- Frame length from start detect to strobe: OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks (152 at defaults).
- Back-to-back frames: a start bit that immediately follows the stop bit is caught. Returning to IDLE at the stop-bit midpoint leaves ½ bit of margin.
- Sampling-point error tolerated: ±OVERSAMPLE/2−1 ticks of accumulated drift per frame.

## Test plan
- **Single byte:** OVERSAMPLE = 16, `tick` every 4 `clkin`; send 0x55 at 1 stop bit.
  - Exactly one `rx_valid` pulse; `rx_data` = 0x55; `frame_err` never high.
- **Back-to-back frames:** 0xA3 then 0x00 with zero idle between them.
  - Two `rx_valid` pulses, 160 ticks apart; data 0xA3 then 0x00.
- **Glitch rejection:** `rxd` low for 4 ticks, then high.
  - No strobe; `busy` high for 8 ticks then low; state returns to IDLE.
- **Framing error / break:**
  - Send 0x3C with stop bit = 0, `rxd` then held low for 40 bit-times → one `frame_err` pulse only; `rx_data` keeps its previous value; no new frame starts.
  - Release `rxd` high, then send 0x81 → `rx_valid` with 0x81.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 of 0xF0.
  - All outputs return to reset values; no strobe; a following 0x12 is received correctly.
- **Tick stall:** hold `tick` low for 100 `clkin` cycles mid-frame of 0x7E.
  - State and counters frozen; after `tick` resumes, 0x7E is received with `rx_valid`.
